// File: rtl/dmem_responder.sv
// Single-outstanding DBUS data memory with a programmable response latency.
// Define DMEM_ACCESS_FAULT_EN to fault requests outside BASE_ADDR..BASE_ADDR+SIZE-1.
module dmem_responder #(
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int unsigned SIZE      = 65536,
   parameter int unsigned LATENCY   = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [63:0] req_addr_i,
   input  logic        req_we_i,
   input  logic [63:0] req_wdata_i,
   input  logic [7:0]  req_wstrb_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [63:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned WORDS = SIZE / 8;
   localparam int unsigned IDX_W = $clog2(WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [63:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [63:0]       mem_q [WORDS];
   logic              accept;
   logic              in_range;
   logic              mem_we;
   logic [IDX_W-1:0]  idx;
   logic              unused_addr;

`ifdef DMEM_ACCESS_FAULT_EN
   logic [63:0] offset;

   assign offset      = req_addr_i - BASE_ADDR;
   assign in_range    = (req_addr_i >= BASE_ADDR) && (req_addr_i < BASE_ADDR + 64'(SIZE));
   assign idx         = offset[IDX_W+2:3];
   assign unused_addr = ^{offset[63:IDX_W+3], offset[2:0]};
`else
   // Without the range check the array simply aliases every SIZE bytes.
   localparam logic unused_base = ^BASE_ADDR;

   assign in_range    = 1'b1;
   assign idx         = req_addr_i[IDX_W+2:3];
   assign unused_addr = ^{req_addr_i[63:IDX_W+3], req_addr_i[2:0]};
`endif

   assign req_ready_o = rst_ni && (state_q == S_IDLE);
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      // NOTE: every target gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      mem_we      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_WAIT;
               cnt_d   = 2'(LATENCY - 1);
               err_d   = !in_range;
               rdata_d = (!req_we_i && in_range) ? mem_q[idx] : 64'h0;
               mem_we  = req_we_i && in_range;
            end
         end
         S_WAIT: begin
            if (cnt_q == 2'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 2'd1;
         end
         S_RESP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      rsp_valid_d = (state_d == S_RESP);
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         rdata_q     <= 64'h0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // NOTE: the array has no reset; contents survive rst_ni like real RAM.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int i = 0; i < 8; i++) begin
            if (req_wstrb_i[i]) mem_q[idx][8*i +: 8] <= req_wdata_i[8*i +: 8];
         end
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus random traffic checked against
// a word-indexed reference memory; a second instance covers LATENCY=4.
module tb_dmem_responder;

   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam int unsigned SIZE = 65536;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [63:0] req_addr = '0, req_wdata = '0;
   logic [7:0]  req_wstrb = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [63:0] rsp_rdata;

   logic        q4_req_valid = 1'b0, q4_req_ready, q4_req_we = 1'b0;
   logic [63:0] q4_req_addr = '0, q4_req_wdata = '0;
   logic [7:0]  q4_req_wstrb = '0;
   logic        q4_rsp_valid, q4_rsp_ready = 1'b0, q4_rsp_err;
   logic [63:0] q4_rsp_rdata;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [63:0] ref_mem [int];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.BASE_ADDR(BASE), .SIZE(SIZE), .LATENCY(1)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_we_i(req_we), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
   );

   dmem_responder #(.BASE_ADDR(BASE), .SIZE(SIZE), .LATENCY(4)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(q4_req_valid), .req_ready_o(q4_req_ready), .req_addr_i(q4_req_addr),
      .req_we_i(q4_req_we), .req_wdata_i(q4_req_wdata), .req_wstrb_i(q4_req_wstrb),
      .rsp_valid_o(q4_rsp_valid), .rsp_ready_i(q4_rsp_ready),
      .rsp_rdata_o(q4_rsp_rdata), .rsp_err_o(q4_rsp_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_in_range(input logic [63:0] a);
`ifdef DMEM_ACCESS_FAULT_EN
      return (a >= BASE) && ((a - BASE) < 64'(SIZE));
`else
      return 1'b1;
`endif
   endfunction

   function automatic int model_idx(input logic [63:0] a);
`ifdef DMEM_ACCESS_FAULT_EN
      return int'((a - BASE) / 64'd8);
`else
      return int'((a % 64'(SIZE)) / 64'd8);
`endif
   endfunction

   function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
      logic [63:0] w;
      int          i;
      if (!model_in_range(a)) return;
      i = model_idx(a);
      w = ref_mem.exists(i) ? ref_mem[i] : 64'h0;
      for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[i] = w;
   endfunction

   function automatic logic [63:0] model_read(input logic [63:0] a);
      int i;
      if (!model_in_range(a)) return 64'h0;
      i = model_idx(a);
      return ref_mem.exists(i) ? ref_mem[i] : 64'hx;
   endfunction

   // One full transaction on the LATENCY=1 instance, holding rsp_ready low for bp cycles.
   task automatic run(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] strb, input int bp, input string tag,
                      output logic [63:0] rd, output logic er);
      logic [63:0] exp_rd;
      logic        exp_er;
      int          lat;
      exp_er = !model_in_range(addr);
      exp_rd = we ? 64'h0 : model_read(addr);
      if (we) model_write(addr, wdata, strb);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      rsp_ready = (bp == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({tag, "_busy"}, 64'({rsp_valid, req_ready}), 64'd0);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd1);
      rd = rsp_rdata;
      er = rsp_err;
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_err"}, 64'(er), 64'(exp_er));
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_ctl"}, 64'({rsp_valid, req_ready, rsp_err}), 64'({1'b1, 1'b0, er}));
         check({tag, "_hold_data"}, rsp_rdata, rd);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, "_done"}, 64'({rsp_valid, req_ready}), 64'b01);
   endtask

   initial begin
      logic [63:0] rd;
      logic        er;
      int          a, b, n, k, sel;
      logic [63:0] addr;

      // Reset with a request already presented: it must not be taken.
      req_valid = 1'b1;
      req_addr  = BASE + 64'h10;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_req_ready", 64'(req_ready), 64'd0);
         check("rst_rsp_ctl", 64'({rsp_valid, rsp_err}), 64'd0);
         check("rst_rdata", rsp_rdata, 64'h0);
      end
      req_valid = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk); #1;
      check("post_rst", 64'({req_ready, rsp_valid}), 64'b10);

      run(1'b1, BASE + 64'h10, 64'h1122334455667788, 8'hFF, 0, "wr_full", rd, er);
      run(1'b0, BASE + 64'h10, 64'h0, 8'h00, 0, "rd_full", rd, er);
      check("rd_full_lit", rd, 64'h1122334455667788);

      run(1'b1, BASE + 64'h10, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0, "wr_part", rd, er);
      run(1'b0, BASE + 64'h13, 64'h0, 8'h00, 0, "rd_part", rd, er);
      check("rd_part_lit", rd, 64'h11223344CCCCDDDD);

      run(1'b1, BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, "wr_zero", rd, er);
      check("wr_zero_err", 64'(er), 64'd0);
      run(1'b0, BASE + 64'h10, 64'h0, 8'h00, 5, "bp", rd, er);
      check("bp_lit", rd, 64'h11223344CCCCDDDD);

`ifdef DMEM_ACCESS_FAULT_EN
      run(1'b1, BASE + 64'hFFF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, "wr_top", rd, er);
      run(1'b0, 64'h8001_0000, 64'h0, 8'h00, 0, "oor_rd", rd, er);
      check("oor_rd_lit", 64'({er, rd[0]}), 64'b10);
      run(1'b1, 64'h7FFF_FFF8, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 0, "oor_wr", rd, er);
      check("oor_wr_err", 64'(er), 64'd1);
      run(1'b0, BASE + 64'hFFF8, 64'h0, 8'h00, 0, "top_rd", rd, er);
      check("top_rd_lit", rd, 64'h0123_4567_89AB_CDEF);
`else
      run(1'b1, BASE + 64'h8, 64'h0, 8'hFF, 0, "wr_w1", rd, er);
      run(1'b1, 64'h8001_0008, 64'h5A, 8'h01, 0, "alias_wr", rd, er);
      check("alias_wr_err", 64'(er), 64'd0);
      run(1'b0, BASE + 64'h8, 64'h0, 8'h00, 0, "alias_rd", rd, er);
      check("alias_rd_byte", 64'(rd[7:0]), 64'h5A);
`endif

      // Reset while the response is pending: response dropped, write kept.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = BASE + 64'h18;
      req_wdata = 64'hDEAD_BEEF_0BAD_F00D;
      req_wstrb = 8'hFF;
      rsp_ready = 1'b0;
      check("mid_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      model_write(BASE + 64'h18, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
      @(posedge clk); #1;
      check("mid_valid", 64'(rsp_valid), 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_ctl", 64'({rsp_valid, req_ready, rsp_err}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid_idle", 64'({rsp_valid, req_ready}), 64'b01);
      run(1'b0, BASE + 64'h18, 64'h0, 8'h00, 0, "mid_rd", rd, er);
      check("mid_rd_lit", rd, 64'hDEAD_BEEF_0BAD_F00D);

      // Random traffic over eight words, their aliases and out-of-range mirrors.
      for (int i = 0; i < 8; i++)
         run(1'b1, BASE + 64'(i * 8), {$urandom, $urandom}, 8'hFF, 0, "rnd_init", rd, er);
      for (int i = 0; i < 60; i++) begin
         k    = int'($urandom_range(0, 7));
         sel  = int'($urandom_range(0, 9));
         addr = BASE + 64'(k * 8) + 64'($urandom_range(0, 7));
         if (sel == 8) addr = addr + 64'(SIZE);
         if (sel == 9) addr = addr - 64'(SIZE);
         run(1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, 8'($urandom),
             int'($urandom_range(0, 2)), "rnd", rd, er);
      end

      // LATENCY=4: valid four edges after acceptance, next acceptance no sooner than five.
      q4_rsp_ready = 1'b1;
      q4_req_valid = 1'b1;
      q4_req_addr  = BASE;
      check("l4_ready", 64'(q4_req_ready), 64'd1);
      @(posedge clk); #1;
      a = cyc;
      n = 0;
      while (!q4_rsp_valid && n < 20) begin
         check("l4_wait_ready", 64'(q4_req_ready), 64'd0);
         @(posedge clk); #1;
         n++;
      end
      check("l4_lat", 64'(cyc - a), 64'd4);
      n = 0;
      while (!q4_req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      b = cyc;
      q4_req_valid = 1'b0;
      check("l4_gap", 64'((b - a) >= 5), 64'd1);
      check("l4_reaccept", 64'(q4_req_ready), 64'd0);
      repeat (10) @(posedge clk);
      #1;
      check("l4_drained", 64'({q4_rsp_valid, q4_req_ready}), 64'b01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
